// File: rtl/osd_trace_packetization_mc.sv
// Round-robin multi-channel trace packetizer: one trace event per DII packet of 16-bit flits.
// Optional timestamp flits (TS_LO/TS_HI after SOURCE) are built when OSD_TRACE_TIMESTAMP_EN is defined.
module osd_trace_packetization_mc #(
    parameter int WIDTH        = 32,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   id,
    input  logic [15:0]                   dest,
    input  logic [NUM_CHANNELS*WIDTH-1:0] trace_data,
    input  logic [NUM_CHANNELS-1:0]       trace_overflow,
    input  logic [NUM_CHANNELS-1:0]       trace_valid,
    output logic [NUM_CHANNELS-1:0]       trace_ready,
    output logic [15:0]                   debug_out_data,
    output logic                          debug_out_valid,
    output logic                          debug_out_last,
    input  logic                          debug_out_ready
);
    // state  | meaning
    // IDLE   | DEST flit offered while any channel is valid; arbitration open
    // SOURCE | header flit: type, channel, overflow flag, timestamp flag, id
    // TS_LO  | captured timestamp [15:0] (timestamp build only)
    // TS_HI  | captured timestamp [31:16] (timestamp build only)
    // STATUS | overflow count, final flit
    // EVENT  | payload slices, least significant first, final one flagged last

    localparam int NUM_FLITS = (WIDTH + 15) / 16;
    localparam int PAD_W     = NUM_FLITS * 16;
    localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SOURCE,
`ifdef OSD_TRACE_TIMESTAMP_EN
        TS_LO,
        TS_HI,
`endif
        STATUS,
        EVENT
    } state_t;

    state_t               state, state_next;
    logic [1:0]           grant, last_grant, cand;
    logic [CNT_W-1:0]     counter;
    logic [NUM_CHANNELS-1:0] valid_rot;
    logic [2:0]           rr_start, rr_sum;
    logic [WIDTH-1:0]     sel_data;
    logic                 sel_ovf;
    logic [PAD_W-1:0]     padded;
    logic [15:0]          event_flit;
    logic [15:0]          data_c;
    logic                 valid_c, last_c;
    logic                 accept, pkt_done;
    logic                 unused_ok;

`ifdef OSD_TRACE_TIMESTAMP_EN
    localparam logic TS_FLAG = 1'b1;
    logic [31:0] ts_count, ts_capture;
`else
    localparam logic TS_FLAG = 1'b0;
`endif

    // Rotate the valid vector so bit 0 is the channel after last_grant; lowest set bit wins.
    always_comb begin
        rr_start  = {1'b0, last_grant} + 3'd1;
        valid_rot = NUM_CHANNELS'({trace_valid, trace_valid} >> rr_start);
        rr_sum    = rr_start;
        for (int j = NUM_CHANNELS - 1; j >= 0; j--) begin
            if (valid_rot[j]) rr_sum = rr_start + 3'(j);
        end
        if (rr_sum >= 3'(NUM_CHANNELS)) rr_sum = rr_sum - 3'(NUM_CHANNELS);
        cand = rr_sum[1:0];
    end

    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant == 2'(c)) begin
                sel_data = trace_data[c*WIDTH +: WIDTH];
                sel_ovf  = trace_overflow[c];
            end
        end
        padded              = '0;
        padded[WIDTH-1:0]   = sel_data;
        event_flit          = 16'h0;
        for (int k = 0; k < NUM_FLITS; k++) begin
            if (counter == CNT_W'(k)) event_flit = padded[k*16 +: 16];
        end
    end

    always_comb begin
        state_next = state;
        data_c     = 16'h0;
        valid_c    = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                valid_c = |trace_valid;
                data_c  = dest;
                if (valid_c && debug_out_ready) state_next = SOURCE;
            end
            SOURCE: begin
                valid_c = 1'b1;
                data_c  = {2'h2, grant, sel_ovf, TS_FLAG, id[9:0]};
                if (debug_out_ready) begin
`ifdef OSD_TRACE_TIMESTAMP_EN
                    state_next = TS_LO;
`else
                    state_next = sel_ovf ? STATUS : EVENT;
`endif
                end
            end
`ifdef OSD_TRACE_TIMESTAMP_EN
            TS_LO: begin
                valid_c = 1'b1;
                data_c  = ts_capture[15:0];
                if (debug_out_ready) state_next = TS_HI;
            end
            TS_HI: begin
                valid_c = 1'b1;
                data_c  = ts_capture[31:16];
                if (debug_out_ready) state_next = sel_ovf ? STATUS : EVENT;
            end
`endif
            STATUS: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
                data_c  = {1'b1, 5'h0, padded[9:0]};
                if (debug_out_ready) state_next = IDLE;
            end
            EVENT: begin
                valid_c = 1'b1;
                data_c  = event_flit;
                last_c  = (counter == CNT_W'(NUM_FLITS - 1));
                if (debug_out_ready && last_c) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while rst is high so an abandoned packet never pulses ready.
    assign debug_out_valid = valid_c & ~rst;
    assign debug_out_data  = debug_out_valid ? data_c : 16'h0;
    assign debug_out_last  = last_c & debug_out_valid;
    assign accept          = debug_out_valid & debug_out_ready;
    assign pkt_done        = accept & debug_out_last;

    always_comb begin
        trace_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            trace_ready[c] = pkt_done && (grant == 2'(c));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'(NUM_CHANNELS - 1);
            counter    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) grant <= cand;
            if (pkt_done) last_grant <= grant;
            if (state == SOURCE) begin
                counter <= '0;
            end else if (state == EVENT && accept) begin
                counter <= debug_out_last ? '0 : counter + CNT_W'(1);
            end
        end
    end

`ifdef OSD_TRACE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_count   <= 32'h0;
            ts_capture <= 32'h0;
        end else begin
            ts_count <= ts_count + 32'd1;
            if (state == IDLE && accept) ts_capture <= ts_count;
        end
    end
`endif

    assign unused_ok = ^{id[15:10], rr_sum[2]};

endmodule

// File: tb/tb_osd_trace_packetization_mc.sv
// Bench for osd_trace_packetization_mc: two instances (WIDTH 32 and 20) checked against a packet-level model.
module tb_osd_trace_packetization_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] id, dest;
    logic        out_ready;

    logic [1:0]  tv_a, ov_a, tr_a;
    logic [31:0] td_a [2];
    logic [63:0] bus_a;
    logic [15:0] data_a;
    logic        valid_a, last_a;

    logic [1:0]  tv_b, ov_b, tr_b;
    logic [19:0] td_b [2];
    logic [39:0] bus_b;
    logic [15:0] data_b;
    logic        valid_b, last_b;

    assign bus_a = {td_a[1], td_a[0]};
    assign bus_b = {td_b[1], td_b[0]};

    osd_trace_packetization_mc #(.WIDTH(32), .NUM_CHANNELS(2)) dut_a (
        .clk(clk), .rst(rst), .id(id), .dest(dest),
        .trace_data(bus_a), .trace_overflow(ov_a), .trace_valid(tv_a), .trace_ready(tr_a),
        .debug_out_data(data_a), .debug_out_valid(valid_a), .debug_out_last(last_a),
        .debug_out_ready(out_ready)
    );

    osd_trace_packetization_mc #(.WIDTH(20), .NUM_CHANNELS(2)) dut_b (
        .clk(clk), .rst(rst), .id(id), .dest(dest),
        .trace_data(bus_b), .trace_overflow(ov_b), .trace_valid(tv_b), .trace_ready(tr_b),
        .debug_out_data(data_b), .debug_out_valid(valid_b), .debug_out_last(last_b),
        .debug_out_ready(out_ready)
    );

    int errors = 0;
    int checks = 0;
    int sel = 0;
    int lg [2];
    int wd [2] = '{32, 20};

    logic [15:0] o_data;
    logic        o_valid, o_last;
    logic [1:0]  o_tr;
    assign o_data  = (sel == 0) ? data_a  : data_b;
    assign o_valid = (sel == 0) ? valid_a : valid_b;
    assign o_last  = (sel == 0) ? last_a  : last_b;
    assign o_tr    = (sel == 0) ? tr_a    : tr_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ch(input int s, input int c, input logic v, input logic o, input logic [31:0] d);
        if (s == 0) begin
            tv_a[c] = v; ov_a[c] = o; td_a[c] = d;
        end else begin
            tv_b[c] = v; ov_b[c] = o; td_b[c] = d[19:0];
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < 2; c++) begin
            drive_ch(0, c, 1'b0, 1'b0, 32'h0);
            drive_ch(1, c, 1'b0, 1'b0, 32'h0);
        end
    endtask

    function automatic logic [1:0] get_valid(input int s);
        return (s == 0) ? tv_a : tv_b;
    endfunction

    function automatic logic [31:0] get_data(input int s, input int c);
        return (s == 0) ? td_a[c] : {12'h0, td_b[c]};
    endfunction

    function automatic logic get_ovf(input int s, input int c);
        return (s == 0) ? ov_a[c] : ov_b[c];
    endfunction

    // Round robin: first valid channel after the previous winner, wrapping.
    function automatic int rr_pick(input int last, input logic [1:0] v);
        for (int k = 1; k <= 2; k++) begin
            int idx;
            idx = (last + k) % 2;
            if (((v >> idx) & 2'b01) != 2'b00) return idx;
        end
        return 0;
    endfunction

    // Runs one packet on instance s; called right after a posedge with inputs already set.
    task automatic run_packet(input int s, input int rmode);
        logic [16:0] q[$];
        int ch, n, idx, cyc, nf;
        logic [31:0] d;
        logic o;
        sel = s;
        ch = rr_pick(lg[s], get_valid(s));
        d  = get_data(s, ch);
        o  = get_ovf(s, ch);
        q = {};
        q.push_back({1'b0, dest});
        q.push_back({1'b0, 16'h8000 | 16'(ch << 12) | (o ? 16'h0800 : 16'h0000) | {6'h0, id[9:0]}});
        if (o) begin
            q.push_back({1'b1, 16'h8000 | {6'h0, d[9:0]}});
        end else begin
            nf = (wd[s] + 15) / 16;
            for (int k = 0; k < nf; k++) q.push_back({(k == nf - 1), 16'(d >> (16 * k))});
        end
        n = q.size();
        out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < n) begin
            if (cyc >= 100) begin
                chk("packet_timeout_flits", idx, n);
                break;
            end
            @(negedge clk);
            cyc++;
            chk("flit_valid", {31'h0, o_valid}, 32'h1);
            chk("flit_data", {16'h0, o_data}, {16'h0, q[idx][15:0]});
            chk("flit_last", {31'h0, o_last}, {31'h0, q[idx][16]});
            if (out_ready) begin
                chk("trace_ready", {30'h0, o_tr}, (idx == n - 1) ? (32'h1 << ch) : 32'h0);
                idx++;
            end else begin
                chk("trace_ready_stall", {30'h0, o_tr}, 32'h0);
            end
            if (idx < n) begin
                @(posedge clk);
                #1;
                if (rmode == 1)      out_ready = ~out_ready;
                else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
                else                 out_ready = 1'b1;
            end
        end
        if (idx == n) lg[s] = ch;
    endtask

    task automatic idle_check(input int s);
        sel = s;
        @(negedge clk);
        chk("idle_valid", {31'h0, o_valid}, 32'h0);
        chk("idle_data", {16'h0, o_data}, 32'h0);
        chk("idle_ready", {30'h0, o_tr}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s, g;
        logic [1:0] v;
        rst = 1'b1;
        id = 16'h0005;
        dest = 16'h0001;
        out_ready = 1'b1;
        clear_all();
        tv_a = 2'b01;
        lg[0] = 1;
        lg[1] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sel = 0;
        @(negedge clk);
        chk("rst_valid_a", {31'h0, valid_a}, 32'h0);
        chk("rst_data_a", {16'h0, data_a}, 32'h0);
        chk("rst_last_a", {31'h0, last_a}, 32'h0);
        chk("rst_ready_a", {30'h0, tr_a}, 32'h0);
        chk("rst_valid_b", {31'h0, valid_b}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_all();
        idle_check(0);
        idle_check(1);

        // 32-bit event on channel 0
        drive_ch(0, 0, 1'b1, 1'b0, 32'hDEADBEEF);
        run_packet(0, 0);
        @(posedge clk); #1;
        clear_all();

        // 20-bit event on channel 1
        drive_ch(1, 1, 1'b1, 1'b0, 32'h000ABCDE);
        run_packet(1, 0);
        @(posedge clk); #1;
        clear_all();

        // overflow record on channel 1
        drive_ch(0, 1, 1'b1, 1'b1, 32'h000003FF);
        run_packet(0, 0);
        @(posedge clk); #1;
        clear_all();

        // both channels continuously valid: grants must alternate
        drive_ch(0, 0, 1'b1, 1'b0, $urandom);
        drive_ch(0, 1, 1'b1, 1'b0, $urandom);
        for (int p = 0; p < 4; p++) begin
            run_packet(0, 0);
            @(posedge clk); #1;
            drive_ch(0, lg[0], 1'b1, 1'b0, $urandom);
        end
        clear_all();

        // ready toggling during a 32-bit event
        drive_ch(0, 0, 1'b1, 1'b0, 32'h12345678);
        run_packet(0, 1);
        @(posedge clk); #1;
        clear_all();

        // reset in the middle of an EVENT packet
        sel = 0;
        out_ready = 1'b1;
        drive_ch(0, 1, 1'b1, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_event_data", {16'h0, data_a}, 32'h0000F00D);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'h0, valid_a}, 32'h0);
        chk("mid_rst_ready", {30'h0, tr_a}, 32'h0);
        chk("mid_rst_data", {16'h0, data_a}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        lg[0] = 1;
        lg[1] = 1;
        drive_ch(0, 0, 1'b1, 1'b0, $urandom);
        run_packet(0, 0);
        @(posedge clk); #1;
        clear_all();

        // randomized packets on both widths
        for (int it = 0; it < 30; it++) begin
            s = int'($urandom_range(0, 1));
            if (it % 5 == 0) idle_check(s);
            v = 2'($urandom_range(1, 3));
            for (int c = 0; c < 2; c++) begin
                g = int'($urandom_range(0, 3));
                drive_ch(s, c, v[c], (g == 0), $urandom);
            end
            run_packet(s, int'($urandom_range(0, 2)));
            @(posedge clk); #1;
            clear_all();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
